// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use / branch-flush / multi-cycle hazard controller for a 5-stage MIPS pipeline
// Optional feature macro: HAZ_PERF_CNT_EN adds the stall_cnt / flush_cnt performance counters.
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   id_rs, id_rt                source register fields of the instruction in ID
//   id_uses_rs, id_uses_rt      ID instruction actually reads rs / rt
//   id_mc_op                    ID instruction is a multi-cycle op (mult/div)
//   ex_mem_read, ex_rt          EX-stage load indication and its destination register
//   ex_br_taken                 branch in EX resolved taken
//   mc_done                     multi-cycle unit completion pulse
//   pc_write, ifid_write        PC / IF-ID register enables
//   ifid_flush                  IF-ID register cleared to NOP
//   idex_write, idex_bubble     ID-EX enable / zeroed control fields
//   mc_start                    registered start pulse to the multi-cycle unit
//   mc_err                      sticky multi-cycle timeout flag
//   stall_cnt, flush_cnt        saturating performance counters (HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_mc_op,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_br_taken,
    input  logic             mc_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             mc_start,
    output logic             mc_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam int WW = $clog2(MC_TIMEOUT + 1);

    typedef enum logic {RUN, MC_BUSY} state_t;

    state_t        state, state_nxt;
    logic [WW-1:0] wait_cnt;
    logic          load_use;
    logic          timeout;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));

    // Fires in the last allowed waiting cycle; the counter then lands on MC_TIMEOUT.
    assign timeout = (state == MC_BUSY) && !mc_done && (wait_cnt == WW'(MC_TIMEOUT - 1));

    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        if (state == RUN) begin
            if (ex_br_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end else if (id_mc_op) begin
                state_nxt = MC_BUSY;
            end
        end else if (mc_done || timeout) begin
            // Pipeline is released this cycle, so the ID instruction still needs load-use protection.
            state_nxt = RUN;
            if (load_use) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end else begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            mc_start <= 1'b0;
            mc_err   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            mc_start <= (state == RUN) && (state_nxt == MC_BUSY);
            wait_cnt <= (state == RUN) ? '0 : wait_cnt + 1'b1;
            if (timeout)
                mc_err <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (state == RUN && load_use && !ex_br_taken && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
            if (ifid_flush && !(&flush_cnt))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rs, id_uses_rt, id_mc_op, ex_mem_read, ex_br_taken, mc_done;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mc_start, mc_err;
    logic [6:0] ctl;
    int         checks = 0;
    int         errors = 0;
`ifdef HAZ_PERF_CNT_EN
    logic [15:0] stall_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mc_start, mc_err}
    assign ctl = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mc_start, mc_err};

    pipe_hazard_ctrl #(.MC_TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_mc_op(id_mc_op), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_br_taken(ex_br_taken), .mc_done(mc_done),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .mc_start(mc_start), .mc_err(mc_err)
`ifdef HAZ_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mc_op = 1'b0;
        ex_mem_read = 1'b0; ex_br_taken = 1'b0; mc_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle();
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL reset_asserted ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL reset_released ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL load_use_rs ctl=%b exp=%b", ctl, 7'b0001100); end
        @(negedge clk); ex_mem_read = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL load_use_one_cycle ctl=%b exp=%b", ctl, 7'b1101000); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt_one got=%0d exp=1", stall_cnt); end
`endif
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL rs_match_unused ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); idle(); ex_mem_read = 1'b1; ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL load_use_rt ctl=%b exp=%b", ctl, 7'b0001100); end
        @(negedge clk); idle(); ex_rt = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL no_mem_read ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); idle();
    endtask

    task automatic test_zero_reg();
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL zero_reg ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); idle();
    endtask

    task automatic test_branch();
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; id_mc_op = 1'b1; ex_br_taken = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1111100) begin errors++; $display("FAIL branch_over_load_use ctl=%b exp=%b", ctl, 7'b1111100); end
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL branch_no_mc_entry ctl=%b exp=%b", ctl, 7'b1101000); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt_branch got=%0d exp=2", stall_cnt); end
        checks++; if (flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt_one got=%0d exp=1", flush_cnt); end
`endif
        @(negedge clk);
    endtask

    task automatic test_mc_op();
        id_mc_op = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL mc_issue ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL mc_busy1 ctl=%b exp=%b", ctl, 7'b0000010); end
        @(negedge clk);
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL mc_busy2 ctl=%b exp=%b", ctl, 7'b0000000); end
        @(negedge clk); ex_br_taken = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL mc_busy3_branch_ignored ctl=%b exp=%b", ctl, 7'b0000000); end
        @(negedge clk); ex_br_taken = 1'b0;
        #1;
        checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL mc_busy4 ctl=%b exp=%b", ctl, 7'b0000000); end
        @(negedge clk); mc_done = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL mc_done_release ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); mc_done = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL mc_back_to_run ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk);
    endtask

    task automatic test_mc_min_dwell();
        id_mc_op = 1'b1;
        @(negedge clk); idle(); mc_done = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
        #1;
        checks++; if (ctl !== 7'b0001110) begin errors++; $display("FAIL mc_done_first_with_load_use ctl=%b exp=%b", ctl, 7'b0001110); end
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL min_dwell_run ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); mc_done = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL late_done_in_run ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk); mc_done = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL late_done_no_entry ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        id_mc_op = 1'b1;
        @(negedge clk); idle();
        #1;
        checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL to_busy1 ctl=%b exp=%b", ctl, 7'b0000010); end
        for (int i = 2; i <= 7; i++) begin
            @(negedge clk);
            #1;
            checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL to_busy%0d ctl=%b exp=%b", i, ctl, 7'b0000000); end
        end
        @(negedge clk);
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL to_release ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk);
        #1;
        checks++; if (ctl !== 7'b1101001) begin errors++; $display("FAIL to_err_set ctl=%b exp=%b", ctl, 7'b1101001); end
        id_mc_op = 1'b1;
        @(negedge clk); idle(); mc_done = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101011) begin errors++; $display("FAIL to_err_sticky ctl=%b exp=%b", ctl, 7'b1101011); end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_mid_busy();
        id_mc_op = 1'b1;
        @(negedge clk); idle();
        @(negedge clk);
        #1;
        checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL rb_busy2 ctl=%b exp=%b", ctl, 7'b0000001); end
        @(negedge clk); rst = 1'b1;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL rb_async_reset ctl=%b exp=%b", ctl, 7'b1101000); end
`ifdef HAZ_PERF_CNT_EN
        checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL rb_counters stall=%0d flush=%0d exp=0", stall_cnt, flush_cnt); end
`endif
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL rb_after_reset ctl=%b exp=%b", ctl, 7'b1101000); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mc_op();
        test_mc_min_dwell();
        test_timeout();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
